// File: rtl/ram_write_arbiter_pkg.sv
// ram_write_arbiter_pkg: shared widths, holding-entry state type and the read-after-write hit compare.
package ram_write_arbiter_pkg;
    localparam int ARG_L  = 8;
    localparam int WORD_L = 16;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_e;
    function automatic logic raw_hit(
        input logic [ARG_L-1:0] rd,
        input logic [ARG_L-1:0] limit,
        input logic             full_c,
        input logic [ARG_L-1:0] addr_c,
        input logic             full_d,
        input logic [ARG_L-1:0] addr_d
    );
        return rd >= limit && ((full_c && rd == addr_c) || (full_d && rd == addr_d));
    endfunction
endpackage

// File: rtl/ram_write_arbiter_hold.sv
// ram_wr_hold: one-entry write buffer with valid/ready accept, grant release and protected-address reject.
module ram_wr_hold
    import ram_write_arbiter_pkg::*;
#(
    parameter int PROT_LIMIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [ARG_L-1:0]  addr,
    input  logic [WORD_L-1:0] data,
    input  logic              grant,
    output logic              ready,
    output logic              full,
    output logic              reject,
    output logic [ARG_L-1:0]  addr_q,
    output logic [WORD_L-1:0] data_q
);
    hold_e             state_q, state_d;
    logic              accept;
    logic [ARG_L-1:0]  addr_d;
    logic [WORD_L-1:0] data_d;
    always_comb begin
        full    = state_q == FULL;
        ready   = !full || grant;
        accept  = valid && ready && addr >= ARG_L'(PROT_LIMIT);
        reject  = valid && ready && addr < ARG_L'(PROT_LIMIT);
        state_d = accept ? FULL : grant ? EMPTY : state_q;
        addr_d  = accept ? addr : addr_q;
        data_d  = accept ? data : data_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: arbitrates core (C) and I/O loader (D) writes onto the ram's single registered write port.
module ram_write_arbiter
    import ram_write_arbiter_pkg::*;
#(
    parameter int PROT_LIMIT = 2,
    parameter int C_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [ARG_L-1:0]  c_addr,
    input  logic [WORD_L-1:0] c_data,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [ARG_L-1:0]  d_addr,
    input  logic [WORD_L-1:0] d_data,
    input  logic [ARG_L-1:0]  rd_a,
    input  logic [ARG_L-1:0]  rd_b,
    output logic [ARG_L-1:0]  pointer_w,
    output logic [WORD_L-1:0] result,
    output logic              stall,
    output logic              prot_err,
    output logic              prot_src,
    output logic              idle
);
    logic              full_c, full_d, rej_c, rej_d, grant_c, grant_d;
    logic [ARG_L-1:0]  c_addr_q, d_addr_q, pointer_w_q, pointer_w_d;
    logic [WORD_L-1:0] c_data_q, d_data_q, result_q, result_d;
    logic              last_q, last_d, pend_q, pend_d;
    logic              prot_err_q, prot_err_d, prot_src_q, prot_src_d;

    ram_wr_hold #(.PROT_LIMIT(PROT_LIMIT)) u_hold_c (
        .clk(clk), .reset(reset), .valid(c_valid), .addr(c_addr), .data(c_data),
        .grant(grant_c), .ready(c_ready), .full(full_c), .reject(rej_c),
        .addr_q(c_addr_q), .data_q(c_data_q)
    );
    ram_wr_hold #(.PROT_LIMIT(PROT_LIMIT)) u_hold_d (
        .clk(clk), .reset(reset), .valid(d_valid), .addr(d_addr), .data(d_data),
        .grant(grant_d), .ready(d_ready), .full(full_d), .reject(rej_d),
        .addr_q(d_addr_q), .data_q(d_data_q)
    );

    // last_q = 1 means D was granted last, so C takes the next tie
    always_comb begin
        grant_c     = full_c && (!full_d || C_PRIORITY != 0 || last_q);
        grant_d     = full_d && !grant_c;
        last_d      = grant_c ? 1'b0 : grant_d ? 1'b1 : last_q;
        pointer_w_d = grant_c ? c_addr_q : grant_d ? d_addr_q : '0;
        result_d    = grant_c ? c_data_q : grant_d ? d_data_q : result_q;
        prot_err_d  = rej_c || rej_d || pend_q;
        prot_src_d  = prot_err_d && !rej_c;
        pend_d      = rej_c && (rej_d || pend_q);
        stall       = raw_hit(rd_a, ARG_L'(PROT_LIMIT), full_c, c_addr_q, full_d, d_addr_q) ||
                      raw_hit(rd_b, ARG_L'(PROT_LIMIT), full_c, c_addr_q, full_d, d_addr_q);
        idle        = !full_c && !full_d && pointer_w_q == '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b1;
            pointer_w_q <= '0;
            result_q    <= '0;
            prot_err_q  <= 1'b0;
            prot_src_q  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            last_q      <= last_d;
            pointer_w_q <= pointer_w_d;
            result_q    <= result_d;
            prot_err_q  <= prot_err_d;
            prot_src_q  <= prot_src_d;
            pend_q      <= pend_d;
        end
    end

    assign pointer_w = pointer_w_q;
    assign result    = result_q;
    assign prot_err  = prot_err_q;
    assign prot_src  = prot_src_q;
endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter: directed scenarios against round-robin and C-priority instances plus a falling-edge ram model.
module tb_ram_write_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        c_valid = 1'b0, d_valid = 1'b0;
    logic [7:0]  c_addr = '0, d_addr = '0, rd_a = '0, rd_b = '0;
    logic [15:0] c_data = '0, d_data = '0;
    logic        rr_c_ready, rr_d_ready, rr_stall, rr_prot_err, rr_prot_src, rr_idle;
    logic [7:0]  rr_pointer_w;
    logic [15:0] rr_result;
    logic        pr_c_ready, pr_d_ready, pr_stall, pr_prot_err, pr_prot_src, pr_idle;
    logic [7:0]  pr_pointer_w;
    logic [15:0] pr_result;
    logic [15:0] mem [256] = '{1: 16'h0001, default: 16'h0000};
    int          vecs = 0, errs = 0;

    ram_write_arbiter #(.PROT_LIMIT(2), .C_PRIORITY(0)) u_rr (
        .clk(clk), .reset(reset),
        .c_valid(c_valid), .c_ready(rr_c_ready), .c_addr(c_addr), .c_data(c_data),
        .d_valid(d_valid), .d_ready(rr_d_ready), .d_addr(d_addr), .d_data(d_data),
        .rd_a(rd_a), .rd_b(rd_b), .pointer_w(rr_pointer_w), .result(rr_result),
        .stall(rr_stall), .prot_err(rr_prot_err), .prot_src(rr_prot_src), .idle(rr_idle)
    );
    ram_write_arbiter #(.PROT_LIMIT(2), .C_PRIORITY(1)) u_pr (
        .clk(clk), .reset(reset),
        .c_valid(c_valid), .c_ready(pr_c_ready), .c_addr(c_addr), .c_data(c_data),
        .d_valid(d_valid), .d_ready(pr_d_ready), .d_addr(d_addr), .d_data(d_data),
        .rd_a(rd_a), .rd_b(rd_b), .pointer_w(pr_pointer_w), .result(pr_result),
        .stall(pr_stall), .prot_err(pr_prot_err), .prot_src(pr_prot_src), .idle(pr_idle)
    );

    always #5 clk = ~clk;

    // ram write port: commits on the falling edge, addresses 0 and 1 ignored
    always @(negedge clk) if (rr_pointer_w > 8'd1) mem[rr_pointer_w] <= rr_result;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        c_valid = 1'b0; d_valid = 1'b0; rd_a = '0; rd_b = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        vecs++; if (rr_c_ready !== 1'b1) begin errs++; $display("FAIL reset_c_ready got %b want 1", rr_c_ready); end
        vecs++; if (rr_d_ready !== 1'b1) begin errs++; $display("FAIL reset_d_ready got %b want 1", rr_d_ready); end
        vecs++; if (rr_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", rr_stall); end
        vecs++; if (rr_idle !== 1'b1) begin errs++; $display("FAIL reset_idle got %b want 1", rr_idle); end
        vecs++; if (rr_pointer_w !== 8'd0) begin errs++; $display("FAIL reset_pointer_w got %0h want 0", rr_pointer_w); end
        vecs++; if (rr_result !== 16'd0) begin errs++; $display("FAIL reset_result got %0h want 0", rr_result); end
        vecs++; if (rr_prot_err !== 1'b0) begin errs++; $display("FAIL reset_prot_err got %b want 0", rr_prot_err); end
        vecs++; if (pr_idle !== 1'b1) begin errs++; $display("FAIL reset_pr_idle got %b want 1", pr_idle); end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        c_valid = 1'b1; c_addr = 8'd5; c_data = 16'h002A;
        tick();
        c_valid = 1'b0; rd_b = 8'd5;
        #1;
        vecs++; if (rr_stall !== 1'b1) begin errs++; $display("FAIL single_stall got %b want 1", rr_stall); end
        vecs++; if (rr_c_ready !== 1'b1) begin errs++; $display("FAIL single_c_ready got %b want 1", rr_c_ready); end
        rd_b = '0;
        tick();
        vecs++; if (rr_pointer_w !== 8'd5) begin errs++; $display("FAIL single_pointer_w got %0h want 5", rr_pointer_w); end
        vecs++; if (rr_result !== 16'h002A) begin errs++; $display("FAIL single_result got %0h want 2a", rr_result); end
        tick();
        vecs++; if (mem[5] !== 16'h002A) begin errs++; $display("FAIL single_ram got %0h want 2a", mem[5]); end
        vecs++; if (rr_idle !== 1'b1) begin errs++; $display("FAIL single_idle got %b want 1", rr_idle); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_pw [10] = '{8'd0, 8'd10, 8'd20, 8'd11, 8'd21, 8'd12, 8'd22, 8'd13, 8'd23, 8'd0};
        logic [7:0] ca = 8'd10, da = 8'd20;
        logic       acc_c, acc_d;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            c_valid = s < 7; d_valid = s < 7;
            c_addr = ca; c_data = {8'h01, ca};
            d_addr = da; d_data = {8'h02, da};
            #1;
            acc_c = c_valid && rr_c_ready;
            acc_d = d_valid && rr_d_ready;
            if (s > 0 && s < 7) begin
                vecs++; if (rr_c_ready !== (s % 2 == 1)) begin errs++; $display("FAIL rr_c_ready step %0d got %b", s, rr_c_ready); end
                vecs++; if (rr_d_ready !== (s % 2 == 0)) begin errs++; $display("FAIL rr_d_ready step %0d got %b", s, rr_d_ready); end
            end
            tick();
            vecs++; if (rr_pointer_w !== exp_pw[s]) begin errs++; $display("FAIL rr_pointer_w step %0d got %0d want %0d", s, rr_pointer_w, exp_pw[s]); end
            if (exp_pw[s] != 8'd0) begin
                vecs++; if (rr_result !== {(exp_pw[s] >= 8'd20) ? 8'h02 : 8'h01, exp_pw[s]}) begin errs++; $display("FAIL rr_result step %0d got %0h", s, rr_result); end
            end
            if (acc_c) ca++;
            if (acc_d) da++;
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp_pw [8] = '{8'd0, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd20, 8'd21};
        logic [7:0] ca = 8'd10, da = 8'd20;
        logic       acc_c, acc_d;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            c_valid = s < 5; d_valid = 1'b1;
            c_addr = ca; c_data = {8'h01, ca};
            d_addr = da; d_data = {8'h02, da};
            #1;
            acc_c = c_valid && pr_c_ready;
            acc_d = d_valid && pr_d_ready;
            if (s > 0) begin
                vecs++; if (pr_d_ready !== (s >= 6)) begin errs++; $display("FAIL pr_d_ready step %0d got %b", s, pr_d_ready); end
            end
            tick();
            vecs++; if (pr_pointer_w !== exp_pw[s]) begin errs++; $display("FAIL pr_pointer_w step %0d got %0d want %0d", s, pr_pointer_w, exp_pw[s]); end
            if (acc_c) ca++;
            if (acc_d) da++;
        end
        c_valid = 1'b0; d_valid = 1'b0;
    endtask

    task automatic test_protect();
        do_reset();
        d_valid = 1'b1; d_addr = 8'd1; d_data = 16'hFFFF;
        #1;
        vecs++; if (rr_d_ready !== 1'b1) begin errs++; $display("FAIL prot_d_ready got %b want 1", rr_d_ready); end
        tick();
        d_valid = 1'b0;
        vecs++; if (rr_prot_err !== 1'b1) begin errs++; $display("FAIL prot_d_err got %b want 1", rr_prot_err); end
        vecs++; if (rr_prot_src !== 1'b1) begin errs++; $display("FAIL prot_d_src got %b want 1", rr_prot_src); end
        vecs++; if (rr_idle !== 1'b1) begin errs++; $display("FAIL prot_d_idle got %b want 1", rr_idle); end
        tick();
        vecs++; if (rr_prot_err !== 1'b0) begin errs++; $display("FAIL prot_d_clear got %b want 0", rr_prot_err); end
        vecs++; if (mem[1] !== 16'h0001) begin errs++; $display("FAIL prot_ram1 got %0h want 1", mem[1]); end
        c_valid = 1'b1; c_addr = 8'd0; d_valid = 1'b1; d_addr = 8'd0;
        tick();
        c_valid = 1'b0; d_valid = 1'b0;
        vecs++; if ({rr_prot_err, rr_prot_src} !== 2'b10) begin errs++; $display("FAIL prot_both_c got %b want 10", {rr_prot_err, rr_prot_src}); end
        tick();
        vecs++; if ({rr_prot_err, rr_prot_src} !== 2'b11) begin errs++; $display("FAIL prot_both_d got %b want 11", {rr_prot_err, rr_prot_src}); end
        tick();
        vecs++; if (rr_prot_err !== 1'b0) begin errs++; $display("FAIL prot_both_clear got %b want 0", rr_prot_err); end
    endtask

    task automatic test_stall();
        do_reset();
        c_valid = 1'b1; c_addr = 8'd5; c_data = 16'h0001;
        tick();
        c_addr = 8'd7; c_data = 16'h0007; d_valid = 1'b1; d_addr = 8'd9; d_data = 16'h0009;
        #1;
        vecs++; if ({rr_c_ready, rr_d_ready} !== 2'b11) begin errs++; $display("FAIL stall_ready got %b want 11", {rr_c_ready, rr_d_ready}); end
        tick();
        c_valid = 1'b0; d_valid = 1'b0; rd_a = 8'd0; rd_b = 8'd7;
        #1;
        vecs++; if (rr_stall !== 1'b1) begin errs++; $display("FAIL stall_held got %b want 1", rr_stall); end
        rd_b = 8'd0;
        #1;
        vecs++; if (rr_stall !== 1'b0) begin errs++; $display("FAIL stall_rd0 got %b want 0", rr_stall); end
        rd_b = 8'd7;
        tick();
        vecs++; if (rr_pointer_w !== 8'd9) begin errs++; $display("FAIL stall_d_first got %0d want 9", rr_pointer_w); end
        vecs++; if (rr_stall !== 1'b1) begin errs++; $display("FAIL stall_still got %b want 1", rr_stall); end
        tick();
        vecs++; if (rr_pointer_w !== 8'd7) begin errs++; $display("FAIL stall_c_grant got %0d want 7", rr_pointer_w); end
        vecs++; if (rr_stall !== 1'b0) begin errs++; $display("FAIL stall_release got %b want 0", rr_stall); end
        rd_b = 8'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_valid = 1'b1; d_addr = 8'd30; d_data = 16'h0077;
        tick();
        d_valid = 1'b0;
        tick();
        vecs++; if (rr_pointer_w !== 8'd30) begin errs++; $display("FAIL mid_pointer_w got %0d want 30", rr_pointer_w); end
        reset = 1'b1;
        #1;
        vecs++; if (rr_pointer_w !== 8'd0) begin errs++; $display("FAIL mid_reset_pw got %0d want 0", rr_pointer_w); end
        vecs++; if (rr_result !== 16'd0) begin errs++; $display("FAIL mid_reset_result got %0h want 0", rr_result); end
        vecs++; if (rr_idle !== 1'b1) begin errs++; $display("FAIL mid_reset_idle got %b want 1", rr_idle); end
        vecs++; if ({rr_c_ready, rr_d_ready} !== 2'b11) begin errs++; $display("FAIL mid_reset_ready got %b want 11", {rr_c_ready, rr_d_ready}); end
        @(negedge clk);
        #1;
        vecs++; if (mem[30] !== 16'd0) begin errs++; $display("FAIL mid_ram30 got %0h want 0", mem[30]); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_priority();
        test_protect();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ram_write_arbiter.md
# ram_write_arbiter

Shares the ram block's single write port (`pointer_w`/`result`, committed on the falling clock edge) between two writers: the core writeback path (requester C) and the I/O loader (requester D). Each requester has a one-entry holding buffer behind a valid/ready handshake; a round-robin arbiter moves one entry per cycle into a registered write port. The block also generates a read-after-write stall for the core's two read pointers and rejects writes to the protected constant cells (addresses 0 and 1).

## Interface
- `PROT_LIMIT`, default 2: addresses below this value are read-only; writes to them are rejected.
- `C_PRIORITY`, default 0: 0 selects round-robin; 1 selects fixed priority, with C always winning.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `c_valid` in 1, `c_ready` out 1, `c_addr` in `` `arg_l ``, `c_data` in `` `word_l ``: core write request.
- `d_valid` in 1, `d_ready` out 1, `d_addr` in `` `arg_l ``, `d_data` in `` `word_l ``: I/O loader write request.
- `rd_a`, `rd_b` in `` `arg_l ``: core read pointers, also driven to the ram `pointer_a`/`pointer_b`.
- `pointer_w` out `` `arg_l ``, `result` out `` `word_l ``: registered write port to the ram.
- `stall` out 1: core must hold its read this cycle.
- `prot_err` out 1, `prot_src` out 1: one-cycle reject pulse and its source (0 = C, 1 = D).
- `idle` out 1: both holding entries are empty and `pointer_w` is 0.

## Operation
- Holding entry per requester, two states:
  - EMPTY to FULL on accept (`x_valid && x_ready` at a rising edge, with `x_addr >= PROT_LIMIT`).
  - FULL to EMPTY when granted.
  - FULL to FULL when granted and a new request is accepted in the same edge.
- `x_ready = !full_x || grant_x` (combinational, pass-through on grant).
- Request with `x_addr < PROT_LIMIT`: accepted (ready honoured) but discarded. `prot_err` = 1 and `prot_src` = x on the next cycle. The entry is not loaded.
- Simultaneous protected rejects from both requesters: C is reported that cycle, D the following cycle; a one-bit pending flag holds D's report.
- Arbitration each rising edge among FULL entries:
  - Round-robin: a one-bit `last` register; the requester not equal to `last` wins a tie. `last` updates on every grant.
  - `C_PRIORITY = 1`: C always wins a tie.
- Output register:
  - On a grant, it loads the winner's addr/data.
  - With no grant, `pointer_w` is set to 0. The ram ignores addresses ≤ 1, so this is a no-op write.
- Same-address writes from C and D: committed in grant order; the later grant's data persists.
- Stall:
  - `stall = (rd_a >= PROT_LIMIT && rd_a matches a FULL entry's addr) || (same for rd_b)`.
  - The output register is excluded: its write commits at the falling edge, before the core samples at the next rising edge.
- Reset, asynchronous:
  - Both entries go EMPTY, `last` = 1, `pointer_w` = 0, `result` = 0, `prot_err` = 0, `prot_src` = 0, pending-reject flag cleared.
  - Pending writes are discarded. Reset asserted between a rising and falling edge suppresses that cycle's ram write.

## Timing
- Reset values: `c_ready` = `d_ready` = 1, `stall` = 0, `idle` = 1, `pointer_w` = 0, `result` = 0, `prot_err` = 0.
- Write latency with no contention:
  - Accept at rising edge k, granted at edge k+1.
  - The ram commits at the falling edge of cycle k+1.
  - Data is readable combinationally from then on, i.e. visible to the core at edge k+2.
- Worst-case wait under round-robin with both requesters saturated: one extra cycle.
- Sustained throughput: one write per cycle in total. Each requester can sustain one per cycle while the other is idle.
- `stall` is asserted combinationally in the same cycle the matching entry is FULL.

## Structure
- Add `` `prot_limit `` (default 2) to `global.v`. Reuse `` `word_l `` and `` `arg_l ``.
- Sub-module `ram_wr_hold`: one-entry buffer holding the full flag, addr and data, with accept, grant and reject logic. It is instantiated twice.
- The top level contains the arbiter, the `last` register, the output register, the stall compare and the error reporting.

## Test plan
- Reset, then C writes addr 5, data 0x2A at edge 1 → `pointer_w` = 5 and `result` = 0x2A after edge 2; the ram reads 0x2A at edge 3; `idle` = 1 after edge 3.
- C and D both valid every cycle (C addr 10.., D addr 20..) → grants alternate C, D, C, D starting with C; `ready` toggles; no request is lost.
- Same as the previous scenario with `C_PRIORITY` = 1 → D is granted only when C deasserts valid.
- D writes addr 1 → `d_ready` = 1, `prot_err` = 1 and `prot_src` = 1 one cycle later; the ram keeps address 1 = 1. C and D both write addr 0 in the same edge → two `prot_err` pulses on consecutive cycles (C, then D).
- C addr 7 held FULL because D won the tie, with `rd_b` = 7 → `stall` = 1 until C's grant edge; `rd_a` = 0 never stalls.
- D accepted at edge k, `reset` pulsed mid-cycle k+1 before the falling edge → no ram write occurs and all outputs return to reset values immediately.
